// File: rtl/ioctl_rom_packer.sv
// Packs data_io download bytes into big-endian 16-bit SDRAM words through a small
// word FIFO. Unpaired bytes are padded with 0xFF.
module ioctl_rom_packer #(
    parameter logic [7:0] INDEX = 8'd0,
    parameter int         DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_downl,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        wr_req,
    output logic [23:0] wr_addr,
    output logic [15:0] wr_data,
    input  logic        wr_ack,
    output logic        rom_loaded,
    output logic        overflow,
    output logic [1:0]  state_dbg
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
    state_t state, state_nxt;

    logic        qual, qual_q, start, accept;
    logic        pend_v, pend_v_nxt;
    logic [23:0] pend_addr, pend_addr_nxt;
    logic [7:0]  pend_data, pend_data_nxt;
    logic [23:0] byte_waddr;
    logic        push_a, push_b, ok_a, ok_b, drop, pop;
    logic [39:0] word_a, word_b;
    logic [39:0] mem [DEPTH];
    logic [AW:0] count, free, n_push;
    logic [AW-1:0] wr_ptr, rd_ptr;

    // qual_q resets high so a download already in progress at reset release is not a start.
    assign qual       = ioctl_downl && (ioctl_index == INDEX);
    assign start      = qual && !qual_q && (state == IDLE || state == DONE);
    assign accept     = ioctl_wr && qual && (state == LOAD || start);
    assign byte_waddr = ioctl_addr[24:1];

    always_comb begin
        push_a        = 1'b0;
        push_b        = 1'b0;
        word_a        = '0;
        word_b        = '0;
        pend_v_nxt    = pend_v;
        pend_addr_nxt = pend_addr;
        pend_data_nxt = pend_data;
        if (accept) begin
            if (!ioctl_addr[0]) begin
                if (pend_v) begin
                    push_a = 1'b1;
                    word_a = {pend_addr, pend_data, 8'hFF};
                end
                pend_v_nxt    = 1'b1;
                pend_addr_nxt = byte_waddr;
                pend_data_nxt = ioctl_dout;
            end else begin
                pend_v_nxt = 1'b0;
                if (pend_v && pend_addr == byte_waddr) begin
                    push_a = 1'b1;
                    word_a = {pend_addr, pend_data, ioctl_dout};
                end else if (pend_v) begin
                    push_a = 1'b1;
                    word_a = {pend_addr, pend_data, 8'hFF};
                    push_b = 1'b1;
                    word_b = {byte_waddr, 8'hFF, ioctl_dout};
                end else begin
                    push_a = 1'b1;
                    word_a = {byte_waddr, 8'hFF, ioctl_dout};
                end
            end
        end else if (state == FLUSH && pend_v) begin
            push_a     = 1'b1;
            word_a     = {pend_addr, pend_data, 8'hFF};
            pend_v_nxt = 1'b0;
        end
    end

    // Handshake: wr_req is high while the FIFO holds a word; the head on wr_addr/wr_data
    // is held until a cycle with wr_req && wr_ack, which pops it. Pop frees space before push.
    assign pop    = wr_ack && (count != '0);
    assign free   = (AW+1)'(DEPTH) - count + {{AW{1'b0}}, pop};
    assign ok_a   = push_a && (free != '0);
    assign ok_b   = push_b && (free > {{AW{1'b0}}, 1'b1});
    assign drop   = (push_a && !ok_a) || (push_b && !ok_b);
    assign n_push = {{AW{1'b0}}, ok_a} + {{AW{1'b0}}, ok_b};

    assign wr_req             = (count != '0);
    assign {wr_addr, wr_data} = wr_req ? mem[rd_ptr] : 40'd0;
    assign rom_loaded         = (state == DONE);
    assign state_dbg          = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = LOAD;
            LOAD:       if (!ioctl_downl) state_nxt = FLUSH;
            FLUSH:      if (!pend_v && count == '0) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            qual_q    <= 1'b1;
            pend_v    <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            qual_q    <= qual;
            pend_v    <= pend_v_nxt;
            pend_addr <= pend_addr_nxt;
            pend_data <= pend_data_nxt;
            count     <= count + n_push - {{AW{1'b0}}, pop};
            wr_ptr    <= wr_ptr + n_push[AW-1:0];
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            overflow  <= (overflow && !start) || drop;
        end
    end

    // Storage carries no reset; outputs are gated by wr_req.
    always_ff @(posedge clk_sys) begin
        if (ok_a) mem[wr_ptr] <= word_a;
        if (ok_b) mem[wr_ptr + AW'(1)] <= word_b;
    end
endmodule

// File: tb/tb_ioctl_rom_packer.sv
// Directed bench for ioctl_rom_packer: stimulus pushes expected words, a monitor acks and checks.
module tb_ioctl_rom_packer;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_downl = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        wr_req;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack = 1'b0;
  logic        rom_loaded;
  logic        overflow;
  logic [1:0]  state_dbg;

  logic        ack_en = 1'b0;
  logic [39:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_FLUSH = 2'd2, S_DONE = 2'd3;

  ioctl_rom_packer #(.INDEX(8'd0), .DEPTH(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rom_loaded(rom_loaded), .overflow(overflow), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk_sys = ~clk_sys;

  // monitor / scoreboard: acks the head and checks it against the expected queue
  always @(negedge clk_sys) begin
    logic [39:0] exp_w;
    if (ack_en && wr_req && !reset) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%h data=%h, expected none", wr_addr, wr_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({wr_addr, wr_data} !== exp_w) begin
          errors++;
          $display("FAIL write got addr=%h data=%h, expected addr=%h data=%h",
                   wr_addr, wr_data, exp_w[39:16], exp_w[15:0]);
        end
      end
      wr_ack = 1'b1;
    end else begin
      wr_ack = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [23:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    @(negedge clk_sys);
    ioctl_downl = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    ioctl_downl = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if (rom_loaded) begin seen = 1; break; end
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk_sys);
    check("rst_wr_req", {31'd0, wr_req}, 32'd0);
    check("rst_wr_addr", {8'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {16'd0, wr_data}, 32'd0);
    check("rst_rom_loaded", {31'd0, rom_loaded}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    reset = 1'b0;
    #1 ack_en = 1'b1;

    // foreign index is ignored
    @(negedge clk_sys);
    ioctl_index = 8'd1; ioctl_downl = 1'b1;
    send_byte(25'd0, 8'h01);
    send_byte(25'd1, 8'h02);
    repeat (4) @(negedge clk_sys);
    check("idx_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    ioctl_downl = 1'b0;
    @(negedge clk_sys);
    ioctl_index = 8'd0;

    // simple pair
    push_exp(24'd0, 16'h1234);
    start_dl();
    check("pair_state_load", {30'd0, state_dbg}, {30'd0, S_LOAD});
    send_byte(25'd0, 8'h12);
    send_byte(25'd1, 8'h34);
    end_dl();
    wait_done("pair_done");
    check("pair_state_done", {30'd0, state_dbg}, {30'd0, S_DONE});

    // three bytes, flush waits for acks
    #1 ack_en = 1'b0;
    start_dl();
    check("restart_rom_loaded", {31'd0, rom_loaded}, 32'd0);
    send_byte(25'd0, 8'hAA);
    send_byte(25'd1, 8'hBB);
    check("latency_wr_req", {31'd0, wr_req}, 32'd1);
    send_byte(25'd2, 8'hCC);
    end_dl();
    repeat (3) @(negedge clk_sys);
    check("flush_state", {30'd0, state_dbg}, {30'd0, S_FLUSH});
    check("flush_rom_loaded", {31'd0, rom_loaded}, 32'd0);
    push_exp(24'd0, 16'hAABB);
    push_exp(24'd1, 16'hCCFF);
    #1 ack_en = 1'b1;
    wait_done("three_done");

    // lone odd, even after even, split pair, high address, flush of trailing even
    push_exp(24'd2, 16'hFF55);
    push_exp(24'd4, 16'h11FF);
    push_exp(24'd5, 16'h2233);
    push_exp(24'h10, 16'hEEFF);
    push_exp(24'h11, 16'hFF44);
    push_exp(24'h800001, 16'hFF77);
    push_exp(24'h800002, 16'h99FF);
    start_dl();
    send_byte(25'd5, 8'h55);
    send_byte(25'd8, 8'h11);
    send_byte(25'd10, 8'h22);
    send_byte(25'd11, 8'h33);
    send_byte(25'h20, 8'hEE);
    send_byte(25'h23, 8'h44);
    send_byte(25'h1000003, 8'h77);
    send_byte(25'h1000004, 8'h99);
    end_dl();
    wait_done("mixed_done");

    // overflow: five words into a four-deep FIFO
    #1 ack_en = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(24'(i), {8'hA0 + 8'(2*i), 8'hA1 + 8'(2*i)});
    start_dl();
    for (int i = 0; i < 10; i++) send_byte(25'(i), 8'hA0 + 8'(i));
    check("ovf_set", {31'd0, overflow}, 32'd1);
    end_dl();
    #1 ack_en = 1'b1;
    wait_done("ovf_done");
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // push into a full FIFO in the same cycle as a pop
    #1 ack_en = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(24'(i), {8'hC0 + 8'(2*i), 8'hC1 + 8'(2*i)});
    push_exp(24'd4, 16'hB0B1);
    start_dl();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) send_byte(25'(i), 8'hC0 + 8'(i));
    send_byte(25'd8, 8'hB0);
    #1 ack_en = 1'b1;
    send_byte(25'd9, 8'hB1);
    check("full_pushpop_ovf", {31'd0, overflow}, 32'd0);
    end_dl();
    wait_done("full_done");

    // reset mid-download with words queued
    #1 ack_en = 1'b0;
    start_dl();
    for (int i = 0; i < 5; i++) send_byte(25'(i), 8'h60 + 8'(i));
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    check("midrst_wr_req", {31'd0, wr_req}, 32'd0);
    check("midrst_rom_loaded", {31'd0, rom_loaded}, 32'd0);
    check("midrst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    reset = 1'b0;
    #1 ack_en = 1'b1;
    send_byte(25'd6, 8'h66);
    send_byte(25'd7, 8'h67);
    repeat (6) @(negedge clk_sys);
    check("midrst_no_load", {30'd0, state_dbg}, {30'd0, S_IDLE});
    check("midrst_no_req", {31'd0, wr_req}, 32'd0);
    end_dl();
    @(negedge clk_sys);
    push_exp(24'd0, 16'h5A5B);
    start_dl();
    send_byte(25'd0, 8'h5A);
    send_byte(25'd1, 8'h5B);
    end_dl();
    wait_done("post_rst_done");

    repeat (5) @(negedge clk_sys);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ioctl_rom_packer.md
IOCTL_ROM_PACKER -- requirements
Module: ioctl_rom_packer

Interface
REQ-001 Parameter INDEX, default 8'd0: value of ioctl_index that this packer accepts.
REQ-002 Parameter DEPTH, default 4: word FIFO depth; power of two, at least 2.
REQ-003 clk_sys  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ioctl_downl  in  1  download in progress, from data_io.
REQ-006 ioctl_index  in  8  download slot index.
REQ-007 ioctl_wr  in  1  one-cycle byte strobe.
REQ-008 ioctl_addr  in  25  byte address of ioctl_dout.
REQ-009 ioctl_dout  in  8  download byte.
REQ-010 wr_req  out  1  SDRAM write request; level signal.
REQ-011 wr_addr  out  24  word address, equal to byte address >> 1.
REQ-012 wr_data  out  16  big-endian word; even byte in [15:8].
REQ-013 wr_ack  in  1  one-cycle acknowledge from the SDRAM controller.
REQ-014 rom_loaded  out  1  ROM image fully written.
REQ-015 overflow  out  1  sticky flag; a word was dropped because the FIFO was full.

Function
REQ-016 A byte is accepted only when ioctl_wr=1, ioctl_downl=1 and ioctl_index==INDEX; all other strobes are ignored.
REQ-017 FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE->LOAD on rising edge of a qualified download.
- LOAD->FLUSH on falling edge of ioctl_downl.
- FLUSH->DONE when the pending byte is cleared and the FIFO is empty.
- DONE->LOAD on a new qualified rising edge.
REQ-018 Even byte (addr[0]=0): stored as pending high byte together with its word address; no FIFO push.
REQ-019 Odd byte, pending valid, same word address: push {pending, byte} and clear pending.
REQ-020 Odd byte, no pending or different word address:
- if pending, first push {pending, 8'hFF};
- then push {8'hFF, byte}.
- This is two pushes, both in the same cycle window (see REQ-023).
REQ-021 Even byte while pending is valid: push {old pending, 8'hFF}, then the new byte becomes pending.
REQ-022 FLUSH with pending valid: push {pending, 8'hFF} in the first FLUSH cycle.
REQ-023 FIFO write side accepts up to 2 pushes per cycle. A push with the FIFO full is dropped and sets overflow; overflow holds until reset or the next download start.
REQ-024 wr_req=1 whenever the FIFO is non-empty. wr_addr and wr_data present the FIFO head and stay stable until wr_ack.
REQ-025 wr_ack while wr_req=1 pops the head. The next word appears on the following cycle, so back-to-back acks give one word per cycle. wr_ack while wr_req=0 is ignored.
REQ-026 Push and pop in the same cycle at full FIFO: the pop frees space first, so the push succeeds.
REQ-027 rom_loaded:
- goes to 1 on entry to DONE;
- goes to 0 on the cycle a new download starts;
- is 0 in IDLE/LOAD/FLUSH.
REQ-028 A byte address bit 24 set is legal; wr_addr = ioctl_addr[24:1] with no wrap.
REQ-029 Latency: a completing odd byte at cycle N gives wr_req=1 at cycle N+1 when the FIFO was empty.

Reset
REQ-030 Reset asserted (at any time, including mid-download) forces: IDLE, FIFO empty, pending cleared, wr_req=0, wr_addr=0, wr_data=0, rom_loaded=0, overflow=0.
REQ-031 After reset release, an already-high ioctl_downl starts no load until it goes low and then high again.

Verification
REQ-032 Bytes 0x12@0, 0x34@1, ioctl_downl falls, ack immediately -> one write: addr 0, data 0x1234; rom_loaded=1 once the FIFO is empty.
REQ-033 Three bytes 0xAA@0, 0xBB@1, 0xCC@2, then download ends -> writes (0,0xAABB) and (1,0xCCFF); DONE only after both are acked.
REQ-034 Byte 0x55@5 with no pending -> write (2, 0xFF55).
REQ-035 wr_ack held 0 while 5 words arrive, DEPTH=4 -> overflow=1; first 4 words are then delivered in order and the 5th never appears.
REQ-036 Reset pulse mid-download with 2 words queued -> wr_req=0 and rom_loaded=0 next cycle; no further writes until a new download rising edge.
REQ-037 Strobes with ioctl_index=1 (INDEX=0) -> no writes; state stays IDLE.
